plateau_detector: RTL and testbench
===================================

PLATEAU_DETECTOR -- requirements
Module: plateau_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, component width of raw samples; autocorrelation components are 2*WIDTH bits.
REQ-002 SHALL have parameter LENGTH, default 16, consecutive above-threshold samples needed for a detection.
REQ-003 SHALL have parameter HOLDOFF, default 160, samples ignored after a reported detection.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32, width of the sample index.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, search enable.
REQ-008 SHALL have port threshold, input, 2*WIDTH, unsigned magnitude threshold, held stable while enable is high.
REQ-009 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, 4*WIDTH), the autocorrelation stream: real part in [4*WIDTH-1:2*WIDTH], imaginary part in [2*WIDTH-1:0], both signed.
REQ-010 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, COUNT_WIDTH), the detection event stream carrying the index of the plateau start.
REQ-011 SHALL have port busy, output, 1, high in PLATEAU, REPORT and HOLDOFF.

Function
REQ-012 SHALL accept a sample only when s_valid && s_ready on a rising clk edge.
REQ-013 SHALL compute magnitude = |re| + |im| as an unsigned 2*WIDTH+1-bit value; |most negative| SHALL equal 2^(2*WIDTH-1), with no saturation.
REQ-014 SHALL treat a sample as "above" when magnitude >= zero-extended threshold.
REQ-015 SHALL keep a COUNT_WIDTH-bit sample index that increments on every accepted sample in every state and wraps modulo 2^COUNT_WIDTH; the first sample after reset has index 0.
REQ-016 SHALL drive s_ready = 1 in every state except REPORT, where s_ready = 0.
REQ-017 SHALL implement states IDLE, SEARCH, PLATEAU, REPORT and HOLDOFF.
REQ-018 IDLE: samples are accepted and discarded; enable high -> SEARCH.
REQ-019 SEARCH: an accepted above sample -> PLATEAU, with run = 1 and start = that sample's index.
REQ-020 PLATEAU: an accepted above sample increments run; when run reaches LENGTH -> REPORT; an accepted below sample -> SEARCH with run cleared.
REQ-021 SHALL go directly from SEARCH to REPORT when LENGTH == 1.
REQ-022 REPORT: m_valid = 1 and m_data = start, both held stable until m_valid && m_ready; the handshake loads hold = HOLDOFF and moves to HOLDOFF, or to SEARCH if HOLDOFF == 0.
REQ-023 HOLDOFF: each accepted sample decrements hold; the sample taking hold to 0 -> SEARCH; samples in HOLDOFF are never evaluated.
REQ-024 SHALL assert m_valid on the cycle after the sample that completes the plateau is accepted.
REQ-025 SHALL go to IDLE on the next edge when enable is low in SEARCH, PLATEAU or HOLDOFF, clearing run and hold.
REQ-026 SHALL NOT abort REPORT when enable goes low: m_valid stays high until the handshake, then the block goes to IDLE.
REQ-027 SHALL drive m_valid = 0 in every state other than REPORT.

Reset
REQ-028 Reset SHALL set state = IDLE, index = 0, run = 0, hold = 0, start = 0 and m_valid = 0.
REQ-029 During and after reset, outputs SHALL be m_valid = 0, m_data = 0, busy = 0 and s_ready = 1.
REQ-030 Reset SHALL override every other input, including reset asserted mid-REPORT, which drops the pending event.

Structure
REQ-031 The state enum typedef SHALL live in the shared wiphy package.
REQ-032 The L1 magnitude SHALL be a combinational sub-module named complex_magnitude, parameterized by component width.
REQ-033 State, index, run, hold and start SHALL all be registered; m_valid and busy SHALL decode from state.

Verification (WIDTH=16, LENGTH=4, HOLDOFF=8, threshold=1000)
REQ-034 Bench SHALL cover: enable=1, m_ready=1, samples 0-1 re=0/im=0, samples 2-5 re=-600/im=500 -> one event with m_data=2, m_valid high on the cycle after sample 5 is accepted.
REQ-035 Bench SHALL cover: above run at samples 2-4, below at sample 5, above at samples 6-9 -> single event with m_data=6.
REQ-036 Bench SHALL cover: m_ready held low 5 cycles during REPORT -> s_ready=0 and m_data stable for 5 cycles, index frozen; no sample lost.
REQ-037 Bench SHALL cover: continuous above samples after an event -> next event's m_data = first index + 4 + 8.
REQ-038 Bench SHALL cover: enable dropped mid-PLATEAU -> IDLE, busy=0, no event; enable dropped in REPORT -> event still delivered, then IDLE.
REQ-039 Bench SHALL cover: re=-32768, im=-32768 with threshold=65535 -> magnitude 65536 counts as above; reset pulsed mid-REPORT -> m_valid=0 on the next cycle and index restarts at 0.

Source files
------------

// File: rtl/wiphy_pkg.sv
// Shared wiphy definitions used by the plateau detector.
// Contents:
//   plateau_state_t - control states of the plateau detector
//   counter_width   - width needed for a counter that must hold 0..max_value,
//                     never narrower than one bit
package wiphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_PLATEAU,
        ST_REPORT,
        ST_HOLDOFF
    } plateau_state_t;

    function automatic int counter_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/complex_magnitude.sv
// Combinational L1 magnitude |re| + |im| of a complex sample.
// Ports:
//   re, im    - two's complement components, COMP_WIDTH bits each
//   magnitude - unsigned sum, COMP_WIDTH+1 bits so that no input saturates
module complex_magnitude #(
    parameter int COMP_WIDTH = 32
) (
    input  logic [COMP_WIDTH-1:0] re,
    input  logic [COMP_WIDTH-1:0] im,
    output logic [COMP_WIDTH:0]   magnitude
);

    logic [COMP_WIDTH-1:0] abs_re;
    logic [COMP_WIDTH-1:0] abs_im;

    // Negating the most negative value wraps back to the same bit pattern,
    // which read as unsigned is exactly 2^(COMP_WIDTH-1), the true magnitude.
    assign abs_re = re[COMP_WIDTH-1] ? (~re + 1'b1) : re;
    assign abs_im = im[COMP_WIDTH-1] ? (~im + 1'b1) : im;

    assign magnitude = {1'b0, abs_re} + {1'b0, abs_im};

endmodule

// File: rtl/plateau_detector.sv
// Plateau detector: watches a stream of complex autocorrelation samples and
// reports the index of the first sample of a run of LENGTH consecutive
// samples whose L1 magnitude reaches the threshold. After a report, HOLDOFF
// samples are skipped before searching resumes.
// Ports:
//   clk, reset         - single clock, synchronous active-high reset
//   enable             - search enable; low returns to IDLE (except REPORT)
//   threshold          - unsigned magnitude threshold
//   s_valid/s_ready/s_data - sample stream, re in upper half, im in lower half
//   m_valid/m_ready/m_data - detection events carrying the plateau start index
//   busy               - high while in PLATEAU, REPORT or HOLDOFF
module plateau_detector
    import wiphy_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int LENGTH      = 16,
    parameter int HOLDOFF     = 160,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2*WIDTH-1:0]     threshold,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [4*WIDTH-1:0]     s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] m_data,
    output logic                   busy
);

    localparam int RUN_W  = counter_width(LENGTH);
    localparam int HOLD_W = counter_width(HOLDOFF);

    plateau_state_t       state, state_next;
    logic [COUNT_WIDTH-1:0] index;
    logic [COUNT_WIDTH-1:0] start, start_next;
    logic [RUN_W-1:0]     run, run_next, run_inc;
    logic [HOLD_W-1:0]    hold, hold_next;
    logic [2*WIDTH:0]     magnitude;
    logic                 accept;
    logic                 above;
    logic                 plateau_done;

    complex_magnitude #(
        .COMP_WIDTH(2 * WIDTH)
    ) u_magnitude (
        .re       (s_data[4*WIDTH-1:2*WIDTH]),
        .im       (s_data[2*WIDTH-1:0]),
        .magnitude(magnitude)
    );

    assign accept       = s_valid && s_ready;
    assign above        = magnitude >= {1'b0, threshold};
    assign run_inc      = run + 1'b1;
    assign plateau_done = (run_inc == RUN_W'(LENGTH));

    // Next-state logic. Enable low wins over any sample in the searching
    // states; REPORT only leaves on the event handshake.
    always_comb begin
        state_next = state;
        run_next   = run;
        hold_next  = hold;
        start_next = start;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    run_next   = '0;
                end else if (accept && above) begin
                    start_next = index;
                    if (LENGTH == 1) begin
                        state_next = ST_REPORT;
                    end else begin
                        state_next = ST_PLATEAU;
                        run_next   = RUN_W'(1);
                    end
                end
            end
            ST_PLATEAU: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    run_next   = '0;
                end else if (accept) begin
                    if (above) begin
                        run_next = run_inc;
                        if (plateau_done) state_next = ST_REPORT;
                    end else begin
                        state_next = ST_SEARCH;
                        run_next   = '0;
                    end
                end
            end
            ST_REPORT: begin
                if (m_ready) begin
                    run_next = '0;
                    if (!enable) begin
                        state_next = ST_IDLE;
                        hold_next  = '0;
                    end else if (HOLDOFF == 0) begin
                        state_next = ST_SEARCH;
                    end else begin
                        state_next = ST_HOLDOFF;
                        hold_next  = HOLD_W'(HOLDOFF);
                    end
                end
            end
            ST_HOLDOFF: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    hold_next  = '0;
                end else if (accept) begin
                    hold_next = hold - 1'b1;
                    if (hold == HOLD_W'(1)) state_next = ST_SEARCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; the sample index advances on every accepted sample
    // regardless of state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            index <= '0;
            run   <= '0;
            hold  <= '0;
            start <= '0;
        end else begin
            state <= state_next;
            run   <= run_next;
            hold  <= hold_next;
            start <= start_next;
            if (accept) index <= index + 1'b1;
        end
    end

    assign s_ready = (state != ST_REPORT);
    assign m_valid = (state == ST_REPORT);
    assign m_data  = start;
    assign busy    = (state == ST_PLATEAU) || (state == ST_REPORT) || (state == ST_HOLDOFF);

endmodule

// File: tb/tb_plateau_detector.sv
// Self-checking bench for plateau_detector (WIDTH=16, LENGTH=4, HOLDOFF=8).
// A directed vector table, hand-written corner sequences and a randomized
// run are all compared against a behavioural model that tracks streaks of
// above-threshold samples, a count of samples still to skip and a pending
// event.
module tb_plateau_detector;

    localparam int W        = 16;
    localparam int L        = 4;
    localparam int H        = 8;
    localparam int CW       = 32;
    localparam int MOST_NEG = 32'sh8000_0000;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [31:0]   threshold;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_data;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          busy;

    int assert_count;
    int fail_count;

    bit          mdl_active;
    bit          mdl_pend;
    bit          mdl_was_reset;
    logic [31:0] mdl_idx;
    logic [31:0] mdl_first;
    logic [31:0] mdl_pend_idx;
    int          mdl_streak;
    int          mdl_skip;

    typedef struct {
        bit          rst;
        bit          en;
        bit          valid;
        int          re;
        int          im;
        bit          mready;
        bit          exp_mv;
        bit          exp_busy;
        bit          exp_sr;
        bit          chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    plateau_detector #(
        .WIDTH      (W),
        .LENGTH     (L),
        .HOLDOFF    (H),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .threshold(threshold),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural reference: one call per clock edge with the inputs present
    // at that edge.
    task automatic modelStep(input bit rst, input bit en, input bit valid,
                             input int re, input int im, input bit mready);
        longint mag;
        longint ar;
        longint ai;
        bit     acc;
        if (rst) begin
            mdl_active    = 0;
            mdl_pend      = 0;
            mdl_idx       = '0;
            mdl_first     = '0;
            mdl_pend_idx  = '0;
            mdl_streak    = 0;
            mdl_skip      = 0;
            mdl_was_reset = 1;
            return;
        end
        mdl_was_reset = 0;
        acc = valid && !mdl_pend;
        if (mdl_pend) begin
            if (mready) begin
                mdl_pend   = 0;
                mdl_streak = 0;
                if (!en) begin
                    mdl_active = 0;
                    mdl_skip   = 0;
                end else begin
                    mdl_skip = H;
                end
            end
        end else if (!mdl_active) begin
            if (en) mdl_active = 1;
        end else if (!en) begin
            mdl_active = 0;
            mdl_streak = 0;
            mdl_skip   = 0;
        end else if (acc) begin
            if (mdl_skip > 0) begin
                mdl_skip--;
            end else begin
                ar  = longint'(re);
                ai  = longint'(im);
                if (ar < 0) ar = -ar;
                if (ai < 0) ai = -ai;
                mag = ar + ai;
                if (mag >= longint'({32'd0, threshold})) begin
                    if (mdl_streak == 0) mdl_first = mdl_idx;
                    mdl_streak++;
                    if (mdl_streak == L) begin
                        mdl_pend     = 1;
                        mdl_pend_idx = mdl_first;
                        mdl_streak   = 0;
                    end
                end else begin
                    mdl_streak = 0;
                end
            end
        end
        if (acc) mdl_idx = mdl_idx + 32'd1;
    endtask

    task automatic checkOutput();
        checkValue("model_m_valid", m_valid, mdl_pend);
        checkValue("model_s_ready", s_ready, !mdl_pend);
        checkValue("model_busy", busy, mdl_pend || (mdl_streak > 0) || (mdl_skip > 0));
        if (mdl_pend) checkValue("model_m_data", m_data, mdl_pend_idx);
        if (mdl_was_reset) checkValue("model_reset_m_data", m_data, 32'd0);
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit valid,
                                 input int re, input int im, input bit mready);
        reset   = rst;
        enable  = en;
        s_valid = valid;
        s_data  = {re, im};
        m_ready = mready;
        @(posedge clk);
        modelStep(rst, en, valid, re, im, mready);
        #1;
        checkOutput();
    endtask

    task automatic expectOut(input string name, input bit mv, input bit bz, input bit sr);
        checkValue({name, "_m_valid"}, m_valid, mv);
        checkValue({name, "_busy"}, busy, bz);
        checkValue({name, "_s_ready"}, s_ready, sr);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    // Feed above-threshold samples with m_ready low until an event appears,
    // then check its index.
    task automatic waitEvent(input string name, input int budget, input logic [31:0] exp_idx);
        for (int i = 0; i < budget && !m_valid; i++) applyStimulus(0, 1, 1, -600, 500, 0);
        checkValue({name, "_seen"}, m_valid, 1'b1);
        checkValue({name, "_data"}, m_data, exp_idx);
    endtask

    initial begin
        int  re;
        int  im;
        bit  rst;
        bit  en;
        bit  valid;
        bit  mready;
        logic [31:0] held;

        assert_count = 0;
        fail_count   = 0;
        threshold    = 32'd1000;
        reset        = 1'b1;
        enable       = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        m_ready      = 1'b0;

        // Basic detection: zeros at 0-1, plateau at 2-5, event the cycle after 5.
        tbl[0] = '{1, 0, 0,    0,   0, 0, 0, 0, 1, 1, 32'd0};
        tbl[1] = '{0, 1, 0,    0,   0, 0, 0, 0, 1, 0, 32'd0};
        tbl[2] = '{0, 1, 1,    0,   0, 1, 0, 0, 1, 0, 32'd0};
        tbl[3] = '{0, 1, 1,    0,   0, 1, 0, 0, 1, 0, 32'd0};
        tbl[4] = '{0, 1, 1, -600, 500, 1, 0, 1, 1, 0, 32'd0};
        tbl[5] = '{0, 1, 1, -600, 500, 1, 0, 1, 1, 0, 32'd0};
        tbl[6] = '{0, 1, 1, -600, 500, 1, 0, 1, 1, 0, 32'd0};
        tbl[7] = '{0, 1, 1, -600, 500, 1, 1, 1, 0, 1, 32'd2};
        tbl[8] = '{0, 1, 1, -600, 500, 1, 0, 1, 1, 0, 32'd0};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].re, tbl[i].im, tbl[i].mready);
            checkValue($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].exp_mv);
            checkValue($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            checkValue($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].exp_sr);
            if (tbl[i].chk_data) checkValue($sformatf("tbl%0d_m_data", i), m_data, tbl[i].exp_data);
        end

        // Back-pressure during REPORT, then holdoff and the following event.
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, -600, 500, 0);
        expectOut("bp_report", 1, 1, 0);
        held = m_data;
        checkValue("bp_first_data", m_data, 32'd2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, -600, 500, 0);
            expectOut($sformatf("bp_stall%0d", i), 1, 1, 0);
            checkValue($sformatf("bp_stall%0d_data", i), m_data, held);
        end
        applyStimulus(0, 1, 1, -600, 500, 1);
        expectOut("bp_handshake", 0, 1, 1);
        waitEvent("bp_next_event", 40, 32'd14);
        applyStimulus(0, 1, 0, 0, 0, 1);

        // Broken run: above 2-4, below 5, above 6-9.
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, -600, 500, 0);
        applyStimulus(0, 1, 1, 10, -20, 0);
        expectOut("broken_below", 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 600, -500, 0);
        expectOut("broken_event", 1, 1, 0);
        checkValue("broken_event_data", m_data, 32'd6);
        applyStimulus(0, 1, 0, 0, 0, 1);

        // Enable dropped mid-PLATEAU, then enable dropped during REPORT.
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, -600, 500, 0);
        applyStimulus(0, 1, 1, -600, 500, 0);
        expectOut("drop_plateau_before", 0, 1, 1);
        applyStimulus(0, 0, 1, -600, 500, 0);
        expectOut("drop_plateau_after", 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, -600, 500, 1);
            expectOut("disabled_quiet", 0, 0, 1);
        end
        applyStimulus(0, 1, 1, -600, 500, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, -600, 500, 0);
        expectOut("drop_report_reached", 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, -600, 500, 0);
            expectOut("drop_report_kept", 1, 1, 0);
        end
        applyStimulus(0, 0, 1, -600, 500, 1);
        expectOut("drop_report_idle", 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, -600, 500, 1);
            expectOut("idle_after_report", 0, 0, 1);
        end

        // Magnitude boundaries and reset in the middle of REPORT.
        threshold = 32'd65535;
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, -32768, -32768, 0);
        expectOut("mag_65536_above", 0, 1, 1);
        applyStimulus(0, 1, 1, -32767, -32767, 0);
        expectOut("mag_65534_below", 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        threshold = 32'hFFFF_FFFF;
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, MOST_NEG, MOST_NEG, 0);
        expectOut("mag_most_neg_above", 0, 1, 1);
        applyStimulus(0, 1, 1, MOST_NEG, 0, 0);
        expectOut("mag_half_below", 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        threshold = 32'd65535;
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, -32768, -32768, 0);
        expectOut("rst_report_reached", 1, 1, 0);
        applyStimulus(1, 1, 1, -32768, -32768, 0);
        expectOut("rst_mid_report", 0, 0, 1);
        checkValue("rst_mid_report_data", m_data, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, -32768, -32768, 0);
        expectOut("rst_restart_event", 1, 1, 0);
        checkValue("rst_restart_data", m_data, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 1);

        // Randomized traffic around the threshold against the model.
        threshold = 32'd1000;
        doReset();
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 19) != 0);
            valid  = ($urandom_range(0, 3) != 0);
            mready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0: begin re = 600; im = 400; end
                1: begin re = 600; im = 399; end
                2, 3: begin
                    re = int'($urandom_range(0, 400));
                    im = int'($urandom_range(0, 400));
                end
                default: begin
                    re = int'($urandom_range(500, 900));
                    im = int'($urandom_range(500, 900));
                end
            endcase
            if ($urandom_range(0, 1) == 1) re = -re;
            if ($urandom_range(0, 1) == 1) im = -im;
            applyStimulus(rst, en, valid, re, im, mready);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
